// File: rtl/nock_mem_port.sv
// nock_mem_port: parametrised single-port cell memory with a valid/ready
// request side, a registered response, range check and post-reset clear.
//
// Ports:
//   clock, reset_n        : rising-edge clock, async active-low reset
//   req_valid/req_ready   : request handshake (ready only after the sweep)
//   req_we/addr/wdata     : write enable, word address, write data
//   rsp_valid             : one-cycle response pulse
//   rsp_rdata/rsp_err     : response data, out-of-range flag
//   init_done             : clear sweep finished
// Optional: define NOCK_MEM_OUTREG_EN to add a response output register
// (latency 2 instead of 1).
module nock_mem_port #(
  parameter int DATA_W = 68,
  parameter int ADDR_W = 10,
  parameter int DEPTH = 1024,
  parameter int READ_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_LAST = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t r_state;
  logic [ADDR_W:0] r_cnt;
  logic r_ready;
  logic r_done;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_init;
  logic w_accept;
  logic w_oor;
  logic [IDX_W-1:0] w_idx;
  logic [DATA_W-1:0] w_old;
  logic w_mem_we;
  logic [IDX_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_rsp_data;

  logic r_v1;
  logic r_e1;
  logic [DATA_W-1:0] r_d1;

  assign w_init = (r_state == ST_INIT);
  assign w_accept = req_valid & r_ready;

  // Counter is one bit wider than the address so a full-size
  // memory compares cleanly against DEPTH.
  assign w_oor = ({1'b0, req_addr} >= LP_DEPTH);
  assign w_idx = w_oor ? '0 : req_addr[IDX_W-1:0];
  assign w_old = r_mem[w_idx];

  assign w_mem_we = w_init | (w_accept & req_we & ~w_oor);
  assign w_mem_addr = w_init ? r_cnt[IDX_W-1:0] : w_idx;
  assign w_mem_wdata = w_init ? INIT_VAL : req_wdata;

  // Read-first sees the pre-edge array value; write-first
  // forwards the incoming data.
  always_comb begin
    w_rsp_data = w_old;
    if (w_oor) begin
      w_rsp_data = '0;
    end else if (req_we && (READ_MODE == 0)) begin
      w_rsp_data = req_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
      r_cnt <= '0;
      r_ready <= 1'b0;
      r_done <= 1'b0;
    end else begin
      unique case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LP_LAST) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
            r_done <= 1'b1;
          end
        end
        ST_RUN: begin
          r_ready <= 1'b1;
          r_done <= 1'b1;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // Data holds between responses; the error flag is a pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_v1 <= 1'b0;
      r_e1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      r_v1 <= w_accept;
      r_e1 <= w_accept & w_oor;
      if (w_accept) begin
        r_d1 <= w_rsp_data;
      end
    end
  end

`ifdef NOCK_MEM_OUTREG_EN
  logic r_v2;
  logic r_e2;
  logic [DATA_W-1:0] r_d2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_v2 <= 1'b0;
      r_e2 <= 1'b0;
      r_d2 <= '0;
    end else begin
      r_v2 <= r_v1;
      r_e2 <= r_e1;
      if (r_v1) begin
        r_d2 <= r_d1;
      end
    end
  end

  assign rsp_valid = r_v2;
  assign rsp_err = r_e2;
  assign rsp_rdata = r_d2;
`else
  assign rsp_valid = r_v1;
  assign rsp_err = r_e1;
  assign rsp_rdata = r_d1;
`endif

  assign req_ready = r_ready;
  assign init_done = r_done;

endmodule

// File: tb/tb_nock_mem_port.sv
// tb_nock_mem_port: scoreboard bench for nock_mem_port, with a
// write-first and a read-first instance driven by the same requests.
module tb_nock_mem_port;

  localparam int DW = 68;
  localparam int AW = 5;
  localparam int DEPTH = 16;
`ifdef NOCK_MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  logic req_valid;
  logic req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic rdy0, v0, e0, dn0;
  logic rdy1, v1, e1, dn1;
  logic [DW-1:0] d0, d1;

  nock_mem_port #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
    .READ_MODE(0), .INIT_VAL('0)
  ) u_wf (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(rdy0),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(v0),
    .rsp_rdata(d0), .rsp_err(e0), .init_done(dn0)
  );

  nock_mem_port #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
    .READ_MODE(1), .INIT_VAL('0)
  ) u_rf (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(rdy1),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(v1),
    .rsp_rdata(d1), .rsp_err(e1), .init_done(dn1)
  );

  typedef struct {
    int due;
    logic err;
    logic [DW-1:0] x0;
    logic [DW-1:0] x1;
  } exp_t;

  exp_t sb[$];
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] last0, last1;
  logic run_m;
  int cyc;
  int tests;
  int fails;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    sb.delete();
    last0 = '0;
    last1 = '0;
  endtask

  // Drive one request cycle; push the expectation on accept and
  // pop/compare whatever response is due after the edge.
  task automatic step(input logic v, input logic we,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] wd,
                      input string nm);
    exp_t e;
    req_valid = v;
    req_we = we;
    req_addr = a;
    req_wdata = wd;
    tests++;
    if (rdy0 !== run_m || rdy1 !== run_m) begin
      fails++;
      $display("FAIL %s ready: got %b/%b want %b",
               nm, rdy0, rdy1, run_m);
    end
    if (v && run_m) begin
      e.due = cyc + LAT;
      if (int'(a) >= DEPTH) begin
        e.err = 1'b1;
        e.x0 = '0;
        e.x1 = '0;
      end else begin
        e.err = 1'b0;
        if (we) begin
          e.x0 = wd;
          e.x1 = mem_m[a[3:0]];
          mem_m[a[3:0]] = wd;
        end else begin
          e.x0 = mem_m[a[3:0]];
          e.x1 = mem_m[a[3:0]];
        end
      end
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    cyc++;
    tests++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (v0 !== 1'b1 || v1 !== 1'b1 ||
          e0 !== e.err || e1 !== e.err ||
          d0 !== e.x0 || d1 !== e.x1) begin
        fails++;
        $display("FAIL %s rsp: got v=%b/%b err=%b/%b d=%h/%h want v=1 err=%b d=%h/%h",
                 nm, v0, v1, e0, e1, d0, d1, e.err, e.x0, e.x1);
      end
      last0 = e.x0;
      last1 = e.x1;
    end else begin
      if (v0 !== 1'b0 || v1 !== 1'b0 ||
          e0 !== 1'b0 || e1 !== 1'b0 ||
          d0 !== last0 || d1 !== last1) begin
        fails++;
        $display("FAIL %s idle: got v=%b/%b err=%b/%b d=%h/%h want v=0 err=0 d=%h/%h",
                 nm, v0, v1, e0, e1, d0, d1, last0, last1);
      end
    end
  endtask

  task automatic drain(input string nm);
    repeat (LAT) step(1'b0, 1'b0, '0, '0, nm);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s drain: got %0d pending want 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_outs(input string nm);
    tests++;
    if ({rdy0, v0, e0, dn0, rdy1, v1, e1, dn1} !== 8'h00 ||
        d0 !== '0 || d1 !== '0) begin
      fails++;
      $display("FAIL %s reset outs: got rdy=%b/%b v=%b/%b err=%b/%b done=%b/%b d=%h/%h want all 0",
               nm, rdy0, rdy1, v0, v1, e0, e1, dn0, dn1, d0, d1);
    end
  endtask

  // Release reset and count edges until ready, with a live request.
  task automatic sweep(input string nm);
    int n;
    logic saw_v;
    n = 0;
    saw_v = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = '0;
    reset_n = 1'b1;
    while (rdy0 !== 1'b1 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
      if (v0 || v1) saw_v = 1'b1;
    end
    tests++;
    if (n != DEPTH || rdy1 !== 1'b1) begin
      fails++;
      $display("FAIL %s sweep len: got %0d rdy1=%b want %0d rdy1=1",
               nm, n, rdy1, DEPTH);
    end
    tests++;
    if (dn0 !== 1'b1 || dn1 !== 1'b1 || saw_v) begin
      fails++;
      $display("FAIL %s init_done: got %b/%b rsp_seen=%b want 1/1 0",
               nm, dn0, dn1, saw_v);
    end
    model_clear();
    run_m = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    run_m = 1'b0;
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    check_reset_outs("reset");
  endtask

  task automatic test_sweep_reads();
    sweep("sweep");
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, AW'(i), '0, "init_read");
    end
    drain("init_read");
  endtask

  task automatic test_write_read();
    step(1'b1, 1'b1, 5'd3, 68'hA_DEAD_BEEF_0123_4567, "wr3");
    step(1'b1, 1'b0, 5'd3, '0, "rd3");
    drain("wr_rd");
  endtask

  task automatic test_read_mode();
    step(1'b1, 1'b1, 5'd5, 68'h1, "rm_w1");
    step(1'b1, 1'b1, 5'd5, 68'h2, "rm_w2");
    step(1'b0, 1'b0, '0, '0, "rm_gap");
    step(1'b1, 1'b0, 5'd5, '0, "rm_rd");
    drain("read_mode");
  endtask

  task automatic test_oor();
    step(1'b1, 1'b0, 5'd20, 68'h5, "oor_rd20");
    step(1'b1, 1'b1, 5'd31, 68'hF_FFFF_1234, "oor_wr31");
    step(1'b1, 1'b0, 5'd4, '0, "rd4");
    step(1'b1, 1'b0, 5'd15, '0, "rd15");
    step(1'b1, 1'b1, 5'd16, 68'h7, "oor_wr16");
    step(1'b1, 1'b0, 5'd0, '0, "rd0");
    drain("oor");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, AW'(i), DW'(10 + i), "b2b_wr");
    end
    drain("b2b_wr");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, AW'(i), '0, "b2b_rd");
    end
    drain("b2b_rd");
  endtask

  task automatic test_mid_reset();
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 5'd3;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outs("rst_pending");
    run_m = 1'b0;
    model_clear();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (7) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outs("rst_sweep7");
    @(posedge clock);
    #1;
    sweep("resweep");
    step(1'b1, 1'b0, 5'd3, '0, "rs_rd3");
    step(1'b1, 1'b0, 5'd5, '0, "rs_rd5");
    step(1'b1, 1'b0, 5'd15, '0, "rs_rd15");
    drain("mid_reset");
  endtask

  initial begin
    cyc = 0;
    tests = 0;
    fails = 0;
    test_reset();
    test_sweep_reads();
    test_write_read();
    test_read_mode();
    test_oor();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
